// File: rtl/opacc_pkg.sv
// Shared types and helpers for the outer-product accumulator tile engine.
package opacc_pkg;

    localparam int unsigned EXT_W  = 128;
    localparam int unsigned EXT_IW = 7;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'd0,
        OP_LOAD  = 2'd1,
        OP_MAC   = 2'd2,
        OP_STORE = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_MAC   = 2'd2,
        S_STORE = 2'd3
    } state_e;

    // Extend the low w bits of x to EXT_W bits, sign-filling when sgn is set.
    function automatic logic [EXT_W-1:0] ext_elem(input logic [EXT_W-1:0] x,
                                                  input int unsigned      w,
                                                  input logic             sgn);
        logic [EXT_W-1:0] mask;
        logic             fill;
        mask = (EXT_W'(1) << w) - EXT_W'(1);
        fill = sgn & x[EXT_IW'(w - 1)];
        return (x & mask) | (fill ? ~mask : '0);
    endfunction

endpackage

// File: rtl/opacc_mac_row.sv
// One tile row: VL lanes of extend-multiply-accumulate sharing a single A element.
module opacc_mac_row
    import opacc_pkg::*;
#(
    parameter int unsigned VL   = 4,
    parameter int unsigned IW   = 16,
    parameter int unsigned XLEN = 64
) (
    input  logic [IW-1:0]      a_i,
    input  logic [VL*IW-1:0]   b_i,
    input  logic [VL*XLEN-1:0] acc_i,
    input  logic               signed_i,
    output logic [VL*XLEN-1:0] sum_c
);

    localparam int unsigned PW = 2 * IW;

    logic [PW-1:0] a_x;

    assign a_x = PW'(ext_elem(EXT_W'(a_i), IW, signed_i));

    for (genvar c = 0; c < VL; c++) begin : g_lane
        logic [PW-1:0] b_x;
        logic [PW-1:0] prod;

        assign b_x  = PW'(ext_elem(EXT_W'(b_i[c*IW +: IW]), IW, signed_i));
        // Product is exact in PW bits for both signednesses; widen it the same way.
        assign prod = a_x * b_x;
        assign sum_c[c*XLEN +: XLEN] = acc_i[c*XLEN +: XLEN]
                                     + XLEN'(ext_elem(EXT_W'(prod), PW, signed_i));
    end

endmodule

// File: rtl/opacc_tile_engine.sv
// Command-driven engine holding NREGS accumulator tiles: clear, load, rank-1 MAC, store.
module opacc_tile_engine
    import opacc_pkg::*;
#(
    parameter int unsigned NREGS = 2,
    parameter int unsigned ML    = 4,
    parameter int unsigned VL    = 4,
    parameter int unsigned KMAX  = 16,
    parameter int unsigned IW    = 16,
    parameter int unsigned XLEN  = 64
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      cmd_valid,
    output logic                                      cmd_ready,
    input  logic [1:0]                                cmd_op,
    input  logic [((NREGS > 1) ? $clog2(NREGS) : 1)-1:0] cmd_tile,
    input  logic                                      cmd_signed,
    input  logic [$clog2(KMAX+1)-1:0]                 cmd_len,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [ML*IW-1:0]                          in_a,
    input  logic [VL*IW-1:0]                          in_b,
    input  logic [VL*XLEN-1:0]                        in_c,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [VL*XLEN-1:0]                        out_c,
    output logic                                      out_last,
    output logic                                      busy
);

    localparam int unsigned TW  = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int unsigned TW1 = TW + 1;
    localparam int unsigned LW  = $clog2(KMAX + 1);
    localparam int unsigned RW  = (ML > 1) ? $clog2(ML) : 1;
    localparam int unsigned CW  = (LW > RW) ? LW : RW;
    localparam int unsigned RWD = VL * XLEN;

    localparam logic [TW:0]   NREGS_W = TW1'(NREGS);
    localparam logic [CW-1:0] ML_LAST = CW'(ML - 1);

    state_e          state_q, state_d;
    cmd_op_e         op_q, op_d;
    logic [TW-1:0]   tsel_q, tsel_d;
    logic            sgn_q, sgn_d;
    logic [LW-1:0]   len_q, len_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            cmd_ready_q, cmd_ready_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic            clear_en, load_en, mac_en, beat, last_beat;
    logic            tile_ok;
    logic [RW-1:0]   row_sel;

    logic [RWD-1:0]  tile_rd  [NREGS][ML];
    logic [RWD-1:0]  row_acc  [ML];
    logic [RWD-1:0]  row_sum  [ML];

    assign tile_ok = ({1'b0, tsel_q} < NREGS_W);
    assign row_sel = RW'(cnt_q);

    // LOAD/STORE walk ML rows; MAC walks the latched beat count.
    assign last_beat = (op_q == OP_MAC) ? ((cnt_q + CW'(1)) == CW'(len_q))
                                        : (cnt_q == ML_LAST);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        tsel_d   = tsel_q;
        sgn_d    = sgn_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        clear_en = 1'b0;
        load_en  = 1'b0;
        mac_en   = 1'b0;
        beat     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d   = cmd_op_e'(cmd_op);
                    tsel_d = cmd_tile;
                    sgn_d  = cmd_signed;
                    len_d  = cmd_len;
                    cnt_d  = '0;
                    case (cmd_op_e'(cmd_op))
                        OP_CLEAR: clear_en = 1'b1;
                        OP_LOAD:  state_d  = S_LOAD;
                        OP_MAC:   state_d  = S_MAC;
                        default:  state_d  = S_STORE;
                    endcase
                end
            end
            S_LOAD: begin
                beat    = in_valid && in_ready_q;
                load_en = beat;
            end
            S_MAC: begin
                if (len_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    beat   = in_valid && in_ready_q;
                    mac_en = beat;
                end
            end
            S_STORE: begin
                beat = out_valid_q && out_ready;
            end
            default: state_d = S_IDLE;
        endcase

        if (beat) begin
            if (last_beat) begin
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // Handshake flags are registered copies of the next-state decode.
        cmd_ready_d = (state_d == S_IDLE);
        in_ready_d  = (state_d == S_LOAD) || ((state_d == S_MAC) && (len_d != '0));
        out_valid_d = (state_d == S_STORE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            op_q        <= OP_CLEAR;
            tsel_q      <= '0;
            sgn_q       <= 1'b0;
            len_q       <= '0;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            tsel_q      <= tsel_d;
            sgn_q       <= sgn_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            cmd_ready_q <= cmd_ready_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Tile storage: one register per (tile, row); out-of-range tiles never match.
    for (genvar t = 0; t < NREGS; t++) begin : g_tile
        for (genvar r = 0; r < ML; r++) begin : g_row
            logic [RWD-1:0] row_q;
            logic           clr_hit, load_hit, mac_hit;

            assign clr_hit  = clear_en && (cmd_tile == TW'(t));
            assign load_hit = load_en && (tsel_q == TW'(t)) && (row_sel == RW'(r));
            assign mac_hit  = mac_en && (tsel_q == TW'(t));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    row_q <= '0;
                end else if (clr_hit) begin
                    row_q <= '0;
                end else if (load_hit) begin
                    row_q <= in_c;
                end else if (mac_hit) begin
                    row_q <= row_sum[r];
                end
            end

            assign tile_rd[t][r] = row_q;
        end
    end

    for (genvar r = 0; r < ML; r++) begin : g_mac
        assign row_acc[r] = tile_ok ? tile_rd[tsel_q][r] : '0;

        opacc_mac_row #(
            .VL   (VL),
            .IW   (IW),
            .XLEN (XLEN)
        ) u_row (
            .a_i      (in_a[r*IW +: IW]),
            .b_i      (in_b),
            .acc_i    (row_acc[r]),
            .signed_i (sgn_q),
            .sum_c    (row_sum[r])
        );
    end

    assign cmd_ready = cmd_ready_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_c     = (out_valid_q && tile_ok) ? tile_rd[tsel_q][row_sel] : '0;
    assign out_last  = out_valid_q && (cnt_q == ML_LAST);

endmodule

// File: tb/tb_opacc_tile_engine.sv
// Self-checking bench for opacc_tile_engine: directed vectors, corner sequences and a random model run.
module tb_opacc_tile_engine;

    localparam int NREGS = 3;
    localparam int ML    = 2;
    localparam int VL    = 2;
    localparam int IW    = 8;
    localparam int XLEN  = 32;
    localparam int KMAX  = 16;
    localparam int NT    = 4;

    localparam logic [1:0] C_CLEAR = 2'd0;
    localparam logic [1:0] C_LOAD  = 2'd1;
    localparam logic [1:0] C_MAC   = 2'd2;
    localparam logic [1:0] C_STORE = 2'd3;

    logic                 clk;
    logic                 reset;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [1:0]           cmd_tile;
    logic                 cmd_signed;
    logic [4:0]           cmd_len;
    logic                 in_valid;
    logic                 in_ready;
    logic [ML*IW-1:0]     in_a;
    logic [VL*IW-1:0]     in_b;
    logic [VL*XLEN-1:0]   in_c;
    logic                 out_valid;
    logic                 out_ready;
    logic [VL*XLEN-1:0]   out_c;
    logic                 out_last;
    logic                 busy;

    opacc_tile_engine #(
        .NREGS (NREGS), .ML (ML), .VL (VL), .KMAX (KMAX), .IW (IW), .XLEN (XLEN)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_tile   (cmd_tile),
        .cmd_signed (cmd_signed),
        .cmd_len    (cmd_len),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_c       (in_c),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_c      (out_c),
        .out_last   (out_last),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [XLEN-1:0] model    [NT][ML][VL];
    logic [XLEN-1:0] exp_rows [ML][VL];

    typedef struct {
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] e00, e01, e10, e11;
    } mac_vec_t;

    mac_vec_t vecs [6];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] exp_row(input int r);
        logic [63:0] v;
        v = '0;
        for (int c = 0; c < VL; c++) v[c*XLEN +: XLEN] = exp_rows[r][c];
        return v;
    endfunction

    task automatic set_exp(input int t);
        for (int r = 0; r < ML; r++)
            for (int c = 0; c < VL; c++) exp_rows[r][c] = model[t][r][c];
    endtask

    task automatic model_clear(input int t);
        if (t < NREGS)
            for (int r = 0; r < ML; r++)
                for (int c = 0; c < VL; c++) model[t][r][c] = '0;
    endtask

    task automatic model_reset();
        for (int t = 0; t < NT; t++)
            for (int r = 0; r < ML; r++)
                for (int c = 0; c < VL; c++) model[t][r][c] = '0;
    endtask

    // Reference: elementwise signed/unsigned products in 64-bit arithmetic, wrapped to XLEN.
    task automatic model_mac(input int t, input logic sgn, input logic [15:0] a, input logic [15:0] b);
        longint ea, eb;
        logic [7:0] ar, bc;
        if (t < NREGS)
            for (int r = 0; r < ML; r++)
                for (int c = 0; c < VL; c++) begin
                    ar = a[r*IW +: IW];
                    bc = b[c*IW +: IW];
                    if (sgn) begin
                        ea = longint'($signed(ar));
                        eb = longint'($signed(bc));
                    end else begin
                        ea = longint'(ar);
                        eb = longint'(bc);
                    end
                    model[t][r][c] = XLEN'(longint'(model[t][r][c]) + ea * eb);
                end
    endtask

    task automatic model_load_row(input int t, input int r, input logic [63:0] c_in);
        if (t < NREGS)
            for (int c = 0; c < VL; c++) model[t][r][c] = c_in[c*XLEN +: XLEN];
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send_cmd(input logic [1:0] op, input int t, input logic sgn, input int len);
        int n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("cmd_ready_wait", 64'(cmd_ready), 64'd1);
            return;
        end
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_tile   = 2'(t);
        cmd_signed = sgn;
        cmd_len    = 5'(len);
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    task automatic send_beat(input logic [15:0] a, input logic [15:0] b, input logic [63:0] c);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("in_ready_wait", 64'(in_ready), 64'd1);
            return;
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_c     = c;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Issue STORE and compare each presented row against exp_rows, optionally with random stalls.
    task automatic store_check(input int t, input bit rnd);
        int idx = 0;
        int cyc = 0;
        send_cmd(C_STORE, t, 1'b0, 0);
        while (idx < ML && cyc < 200) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            check("store_valid", 64'(out_valid), 64'd1);
            if (out_valid) begin
                check("store_row", out_c, exp_row(idx));
                check("store_last", 64'(out_last), 64'(idx == ML - 1));
                if (out_ready) idx++;
            end
            @(negedge clk);
            cyc++;
        end
        if (idx < ML) check("store_timeout", 64'(idx), 64'(ML));
        out_ready = 1'b1;
        check("store_idle_valid", 64'(out_valid), 64'd0);
    endtask

    initial begin
        int hs;
        logic [63:0] held;
        logic [1:0]  op;
        int t, len;
        logic sgn;

        vecs[0] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'd65025, 32'd65025, 32'd65025, 32'd65025};
        vecs[1] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'd1, 32'd1, 32'd1, 32'd1};
        vecs[2] = '{1'b1, 16'h02FF, 16'h0403, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'd6, 32'd8};
        vecs[3] = '{1'b0, 16'h0180, 16'h7F02, 32'd256, 32'd16256, 32'd2, 32'd127};
        vecs[4] = '{1'b1, 16'h0180, 16'h7F02, 32'hFFFF_FF00, 32'hFFFF_C080, 32'd2, 32'd127};
        vecs[5] = '{1'b0, 16'h0500, 16'h0007, 32'd0, 32'd0, 32'd35, 32'd0};

        model_reset();
        reset = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_tile = '0; cmd_signed = 1'b0;
        cmd_len = '0; in_valid = 1'b0; in_a = '0; in_b = '0; in_c = '0; out_ready = 1'b1;

        // Reset values
        #12;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last",  64'(out_last),  64'd0);
        check("rst_out_c",     out_c,          64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);

        // LOAD tile1 then STORE it
        send_cmd(C_LOAD, 1, 1'b0, 0);
        send_beat(16'h0, 16'h0, {32'd2, 32'd1});
        model_load_row(1, 0, {32'd2, 32'd1});
        send_beat(16'h0, 16'h0, {32'd4, 32'd3});
        model_load_row(1, 1, {32'd4, 32'd3});
        check("load_done_cmd_ready", 64'(cmd_ready), 64'd1);
        exp_rows[0][0] = 32'd1; exp_rows[0][1] = 32'd2;
        exp_rows[1][0] = 32'd3; exp_rows[1][1] = 32'd4;
        store_check(1, 1'b0);

        // STORE with a 3-cycle stall on row 0
        out_ready = 1'b0;
        send_cmd(C_STORE, 1, 1'b0, 0);
        held = out_c;
        for (int k = 0; k < 3; k++) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_row0",  out_c, exp_row(0));
            check("stall_hold",  out_c, held);
            check("stall_last",  64'(out_last), 64'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        hs = 0;
        for (int k = 0; k < 5; k++) begin
            if (out_valid && out_ready) begin
                if (hs < ML) begin
                    check("stall_row_after", out_c, exp_row(hs));
                    check("stall_last_after", 64'(out_last), 64'(hs == ML - 1));
                end
                hs++;
            end
            @(negedge clk);
        end
        check("stall_handshakes", 64'(hs), 64'd2);

        // Table: single-beat MAC on a cleared tile
        for (int i = 0; i < 6; i++) begin
            send_cmd(C_CLEAR, 0, 1'b0, 0);
            model_clear(0);
            check("clear_stays_idle", 64'({cmd_ready, busy}), 64'b10);
            send_cmd(C_MAC, 0, vecs[i].sgn, 1);
            send_beat(vecs[i].a, vecs[i].b, 64'd0);
            model_mac(0, vecs[i].sgn, vecs[i].a, vecs[i].b);
            exp_rows[0][0] = vecs[i].e00; exp_rows[0][1] = vecs[i].e01;
            exp_rows[1][0] = vecs[i].e10; exp_rows[1][1] = vecs[i].e11;
            store_check(0, 1'b0);
        end

        // Two-beat signed MAC
        send_cmd(C_CLEAR, 0, 1'b0, 0);
        model_clear(0);
        send_cmd(C_MAC, 0, 1'b1, 2);
        send_beat(16'h02FF, 16'h0403, 64'd0);
        send_beat(16'h02FF, 16'h0403, 64'd0);
        model_mac(0, 1'b1, 16'h02FF, 16'h0403);
        model_mac(0, 1'b1, 16'h02FF, 16'h0403);
        exp_rows[0][0] = 32'hFFFF_FFFA; exp_rows[0][1] = 32'hFFFF_FFF8;
        exp_rows[1][0] = 32'd12;        exp_rows[1][1] = 32'd16;
        store_check(0, 1'b0);

        // MAC len0: one busy cycle, tile untouched
        send_cmd(C_MAC, 0, 1'b1, 0);
        check("len0_busy",      64'(busy),      64'd1);
        check("len0_cmd_ready", 64'(cmd_ready), 64'd0);
        check("len0_in_ready",  64'(in_ready),  64'd0);
        @(negedge clk);
        check("len0_busy_next",      64'(busy),      64'd0);
        check("len0_cmd_ready_next", 64'(cmd_ready), 64'd1);
        set_exp(0);
        store_check(0, 1'b0);

        // Out-of-range tile: accepted, nothing written, STORE reads zeros
        send_cmd(C_LOAD, 3, 1'b0, 0);
        send_beat(16'h0, 16'h0, 64'hDEAD_BEEF_1234_5678);
        send_beat(16'h0, 16'h0, 64'hCAFE_F00D_8765_4321);
        send_cmd(C_MAC, 3, 1'b0, 1);
        send_beat(16'h0303, 16'h0505, 64'd0);
        set_exp(3);
        store_check(3, 1'b0);
        set_exp(0);
        store_check(0, 1'b0);

        // Reset after 1 of 3 MAC beats
        send_cmd(C_MAC, 0, 1'b0, 3);
        send_beat(16'h1111, 16'h2222, 64'd0);
        #2 reset = 1'b0;
        #1;
        check("midrst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("midrst_in_ready",  64'(in_ready),  64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_last",  64'(out_last),  64'd0);
        check("midrst_out_c",     out_c,          64'd0);
        check("midrst_busy",      64'(busy),      64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_release_ready", 64'(cmd_ready), 64'd1);
        set_exp(0);
        store_check(0, 1'b0);
        set_exp(1);
        store_check(1, 1'b0);

        // Random commands against the reference model
        for (int it = 0; it < 80; it++) begin
            op  = 2'($urandom_range(0, 3));
            t   = $urandom_range(0, NT - 1);
            sgn = 1'($urandom_range(0, 1));
            len = $urandom_range(0, 4);
            case (op)
                C_CLEAR: begin
                    send_cmd(C_CLEAR, t, sgn, len);
                    model_clear(t);
                end
                C_LOAD: begin
                    send_cmd(C_LOAD, t, sgn, len);
                    for (int r = 0; r < ML; r++) begin
                        logic [63:0] cv;
                        cv = {$urandom, $urandom};
                        repeat ($urandom_range(0, 2)) @(negedge clk);
                        send_beat(16'($urandom), 16'($urandom), cv);
                        model_load_row(t, r, cv);
                    end
                end
                C_MAC: begin
                    send_cmd(C_MAC, t, sgn, len);
                    for (int k = 0; k < len; k++) begin
                        logic [15:0] av, bv;
                        av = 16'($urandom);
                        bv = 16'($urandom);
                        repeat ($urandom_range(0, 2)) @(negedge clk);
                        send_beat(av, bv, 64'($urandom));
                        model_mac(t, sgn, av, bv);
                    end
                    if (len == 0) @(negedge clk);
                end
                default: begin
                    set_exp(t);
                    store_check(t, 1'b1);
                end
            endcase
        end
        for (int tt = 0; tt < NT; tt++) begin
            set_exp(tt);
            store_check(tt, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
